// File: rtl/reg_file.sv
// 32 x 32-bit register file: one synchronous write port, two combinational read ports.
// r0 always reads zero, and r29 mirrors screenEndVal every cycle. Define REGFILE_BYPASS_EN to add write-through forwarding.
module reg_file (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEn,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB,
  input  logic [31:0] screenEndVal
);

  localparam logic [4:0] STATUS_REG = 5'd29;

  // r0 has no storage; only r1..r31 are flops.
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic        write_ok;

  assign write_ok = ctrl_writeEn && (ctrl_writeReg != 5'd0) && (ctrl_writeReg != STATUS_REG);

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      // NOTE: each element is given its hold value first, so no path leaves it unassigned and no latch is inferred.
      regs_d[i] = regs_q[i];
      if (write_ok && (ctrl_writeReg == 5'(i))) regs_d[i] = data_writeReg;
    end
    // The status mirror overrides any write aimed at r29.
    regs_d[STATUS_REG] = screenEndVal;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      // NOTE: this storage array is cleared on reset on purpose, because software expects every register to read 0 after reset.
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register updates from the same pre-edge values.
      for (int i = 1; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_readRegA == 5'(i)) data_readRegA = regs_q[i];
      if (ctrl_readRegB == 5'(i)) data_readRegB = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    // write_ok already excludes r0 and r29, so the forwarded value is always one that will commit.
    if (write_ok && (ctrl_readRegA == ctrl_writeReg)) data_readRegA = data_writeReg;
    if (write_ok && (ctrl_readRegB == ctrl_writeReg)) data_readRegB = data_writeReg;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset and forwarding sequences,
// and random traffic compared against an array model of the register file.
module tb_reg_file;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic [31:0] screenEndVal;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] screen;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  reg_file dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .screenEndVal  (screenEndVal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Architectural rule for one rising edge, applied while reset is high.
  function automatic void model_edge();
    if (ctrl_writeEn && ctrl_writeReg != 5'd0 && ctrl_writeReg != 5'd29)
      model[ctrl_writeReg] = data_writeReg;
    model[29] = screenEndVal;
    model[0]  = 32'd0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endfunction

  // One clock: update the model at the rising edge, then drop the write enable at the falling edge.
  task automatic step();
    @(posedge clock);
    if (ctrl_reset) model_edge();
    @(negedge clock);
    ctrl_writeEn = 1'b0;
    #1;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    #1;
    check($sformatf("%s A r%0d", tag, a), data_readRegA, model[a]);
    check($sformatf("%s B r%0d", tag, b), data_readRegB, model[b]);
  endtask

  initial begin
    ctrl_reset    = 1'b1;
    ctrl_writeEn  = 1'b0;
    ctrl_writeReg = '0;
    data_writeReg = '0;
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
    screenEndVal  = 32'h0000_0000;
    model_clear();
    #1 ctrl_reset = 1'b0;

    // While reset is held, every address pair must read 0. A write during the hold must not commit.
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = 5'd3;
    data_writeReg = 32'h5;
    screenEndVal  = 32'h1234;
    for (int a = 0; a < 32; a++) begin
      ctrl_readRegA = 5'(a);
      ctrl_readRegB = 5'(31 - a);
      #1;
      check($sformatf("rst_hold A r%0d", a), data_readRegA, 32'd0);
      check($sformatf("rst_hold B r%0d", 31 - a), data_readRegB, 32'd0);
    end
    @(posedge clock);
    @(negedge clock);
    read_check("rst_edge", 5'd3, 5'd29);
    ctrl_writeEn = 1'b0;
    screenEndVal = 32'd0;
    #1 ctrl_reset = 1'b1;

    // Directed vector table. Entries apply in order, so each expected value follows from the entries before it.
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 32'd0, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'd0};
    vecs[1] = '{1'b1, 5'd0,  32'd1234,      32'd1, 5'd0,  5'd29, 32'd0,         32'd1};
    vecs[2] = '{1'b1, 5'd29, 32'hFFFF_FFFF, 32'd1, 5'd29, 5'd0,  32'd1,         32'd0};
    vecs[3] = '{1'b0, 5'd29, 32'd0,         32'd7, 5'd29, 5'd5,  32'd7,         32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 5'd10, 32'h11,        32'd7, 5'd10, 5'd29, 32'h11,        32'd7};
    vecs[5] = '{1'b0, 5'd10, 32'd99,        32'd7, 5'd10, 5'd10, 32'h11,        32'h11};
    vecs[6] = '{1'b1, 5'd12, 32'h8000_0000, 32'd7, 5'd12, 5'd10, 32'h8000_0000, 32'h11};
    vecs[7] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'd7, 5'd12, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[8] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 32'd0, 5'd31, 5'd29, 32'hA5A5_A5A5, 32'd0};
    foreach (vecs[k]) begin
      ctrl_writeEn  = vecs[k].we;
      ctrl_writeReg = vecs[k].wreg;
      data_writeReg = vecs[k].wdata;
      screenEndVal  = vecs[k].screen;
      ctrl_readRegA = vecs[k].ra;
      ctrl_readRegB = vecs[k].rb;
      step();
      check($sformatf("vec%0d A", k), data_readRegA, vecs[k].exp_a);
      check($sformatf("vec%0d B", k), data_readRegB, vecs[k].exp_b);
    end

    // Write rN = N*3 for every writable register, then read each register paired with its mirror address.
    screenEndVal = 32'h0BAD_F00D;
    for (int n = 1; n < 32; n++) begin
      if (n == 29) continue;
      ctrl_writeEn  = 1'b1;
      ctrl_writeReg = 5'(n);
      data_writeReg = 32'(n * 3);
      step();
    end
    for (int n = 0; n < 32; n++) begin
      ctrl_readRegA = 5'(n);
      ctrl_readRegB = 5'(31 - n);
      #1;
      check($sformatf("all A r%0d", n), data_readRegA,
            (n == 0) ? 32'd0 : (n == 29) ? 32'h0BAD_F00D : 32'(n * 3));
      check($sformatf("all B r%0d", 31 - n), data_readRegB,
            (31 - n == 0) ? 32'd0 : (31 - n == 29) ? 32'h0BAD_F00D : 32'(3 * (31 - n)));
    end

    // Same-cycle read of the register being written: the old value before the edge unless forwarding is built in.
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = 5'd20;
    data_writeReg = 32'hCAFE_0020;
    ctrl_readRegA = 5'd20;
    ctrl_readRegB = 5'd20;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle A", data_readRegA, 32'hCAFE_0020);
`else
    check("same_cycle A", data_readRegA, 32'd60);
`endif
    step();
    check("after_edge A", data_readRegA, 32'hCAFE_0020);
    check("after_edge B", data_readRegB, 32'hCAFE_0020);

    // Assert reset between edges while a write is pending. The clear is immediate, and the write never commits.
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = 5'd7;
    data_writeReg = 32'd55;
    #2 ctrl_reset = 1'b0;
    model_clear();
    read_check("mid_rst", 5'd7, 5'd31);
    read_check("mid_rst", 5'd20, 5'd29);
    @(posedge clock);
    #1;
    read_check("rst_edge2", 5'd7, 5'd12);
    ctrl_writeEn = 1'b0;
    screenEndVal = 32'h0000_00EE;
    #1 ctrl_reset = 1'b1;
    step();
    read_check("post_rst", 5'd7, 5'd29);
    check("post_rst r7 const", data_readRegA, 32'd0);

    // Random traffic compared against the model after each edge.
    for (int t = 0; t < 300; t++) begin
      ctrl_writeEn  = 1'($urandom_range(0, 3) != 0);
      ctrl_writeReg = 5'($urandom_range(0, 31));
      data_writeReg = $urandom;
      if ($urandom_range(0, 3) == 0) screenEndVal = $urandom;
      step();
      read_check($sformatf("rnd%0d", t), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
